// File: rtl/fdc_multi.sv
// Multi-channel frequency-to-digital converter: counts synchronized VCO rising edges
// over a programmable clk_ref window and presents latched results through a valid/ready port.
module fdc_multi #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GATE_W = 10,
  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_ref,
  input  logic              reset,
  input  logic [NCH-1:0]    vco,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [SEL_W-1:0]  selec,
  output logic [CNT_W-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [NCH-1:0]    ovf
);

  typedef enum logic [1:0] {StIdle, StMeasure, StHold} state_e;

  state_e state_q, state_d;

  logic [NCH-1:0] sync1_q, sync2_q, hist_q;
  logic [NCH-1:0] pulse;

  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_nxt, res_q;
  logic [NCH-1:0]            cnt_ovf_q, cnt_ovf_nxt, res_ovf_q;
  logic [GATE_W-1:0]         win_q, glen_eff;

  logic start_win;
  logic last_cycle;

  assign pulse    = sync2_q & ~hist_q;
  assign glen_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;

  always_comb begin
    state_d    = state_q;
    start_win  = 1'b0;
    last_cycle = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start || cont) begin
          state_d   = StMeasure;
          start_win = 1'b1;
        end
      end
      StMeasure: begin
        if (win_q == GATE_W'(1)) begin
          state_d    = StHold;
          last_cycle = 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          if (cont) begin
            state_d   = StMeasure;
            start_win = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating next count; the last window cycle's pulse is folded in when latching results.
  always_comb begin
    cnt_nxt     = cnt_q;
    cnt_ovf_nxt = cnt_ovf_q;
    for (int i = 0; i < NCH; i++) begin
      if (pulse[i]) begin
        if (cnt_q[i] == '1) begin
          cnt_ovf_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      cnt_q     <= '0;
      cnt_ovf_q <= '0;
      res_q     <= '0;
      res_ovf_q <= '0;
      win_q     <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= vco;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (start_win) begin
        cnt_q     <= '0;
        cnt_ovf_q <= '0;
        win_q     <= glen_eff;
      end else if (state_q == StMeasure) begin
        cnt_q     <= cnt_nxt;
        cnt_ovf_q <= cnt_ovf_nxt;
        win_q     <= win_q - GATE_W'(1);
      end
      if (last_cycle) begin
        res_q     <= cnt_nxt;
        res_ovf_q <= cnt_ovf_nxt;
      end
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (selec == SEL_W'(i)) out = res_q[i];
    end
  end

  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StMeasure);
  assign ovf       = res_ovf_q;

endmodule

// File: tb/tb_fdc_multi.sv
// Scoreboard bench for fdc_multi: periodic VCO stimulus, two instances (8-bit and 4-bit counters).
module tb_fdc_multi;

  logic       clk_ref = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] vco = '0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [9:0] gate_len = '0;
  logic       sel_a = 1'b0;
  logic [1:0] sel_b = '0;
  logic       out_ready = 1'b0;

  logic [7:0] out_a;
  logic [3:0] out_b;
  logic       valid_a, valid_b, busy_a, busy_b;
  logic [1:0] ovf_a;
  logic [2:0] ovf_b;

  int total = 0;
  int bad = 0;
  int per [3] = '{0, 0, 0};
  int ph [3] = '{0, 0, 0};

  typedef struct {int e0; int e1;} exp_t;
  exp_t sb[$];

  fdc_multi #(.NCH(2), .CNT_W(8), .GATE_W(10)) dut_a (
    .clk_ref(clk_ref), .reset(reset), .vco(vco[1:0]), .start(start), .cont(cont),
    .gate_len(gate_len), .selec(sel_a), .out(out_a), .out_valid(valid_a),
    .out_ready(out_ready), .busy(busy_a), .ovf(ovf_a)
  );

  fdc_multi #(.NCH(3), .CNT_W(4), .GATE_W(10)) dut_b (
    .clk_ref(clk_ref), .reset(reset), .vco(vco), .start(start), .cont(cont),
    .gate_len(gate_len), .selec(sel_b), .out(out_b), .out_valid(valid_b),
    .out_ready(out_ready), .busy(busy_b), .ovf(ovf_b)
  );

  always #5 clk_ref = ~clk_ref;

  // Square waves with 50% duty; period 0 holds the channel low.
  always @(negedge clk_ref) begin
    for (int i = 0; i < 3; i++) begin
      if (per[i] == 0) begin
        vco[i] = 1'b0;
      end else begin
        ph[i] = (ph[i] + 1) % per[i];
        vco[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic set_periods(input int p0, input int p1);
    per[0] = p0;
    per[1] = p1;
    repeat (12) tick();
  endtask

  task automatic check_result(input exp_t e);
    chk_eq("valid_a", int'(valid_a), 1);
    chk_eq("valid_b", int'(valid_b), 1);
    chk_eq("busy_hold", int'(busy_a), 0);
    sel_a = 1'b0; sel_b = 2'd0; #1;
    chk_eq("out_a_ch0", int'(out_a), sat(e.e0, 255));
    chk_eq("out_b_ch0", int'(out_b), sat(e.e0, 15));
    sel_a = 1'b1; sel_b = 2'd1; #1;
    chk_eq("out_a_ch1", int'(out_a), sat(e.e1, 255));
    chk_eq("out_b_ch1", int'(out_b), sat(e.e1, 15));
    sel_b = 2'd3; #1;
    chk_eq("out_b_sel_oob", int'(out_b), 0);
    chk_eq("ovf_a", int'(ovf_a), {30'd0, e.e1 > 255, e.e0 > 255});
    chk_eq("ovf_b", int'(ovf_b), {29'd0, 1'b0, e.e1 > 15, e.e0 > 15});
  endtask

  // Wait out a MEASURE phase; returns the number of busy cycles seen.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic run_window(input int glen, input int e0, input int e1, input int hold,
                            input bit hammer);
    exp_t e;
    int n;
    gate_len = 10'(glen);
    start = 1'b1;
    sb.push_back('{e0: e0, e1: e1});
    tick();
    if (!hammer) start = 1'b0;
    gate_len = 10'(glen + 7);
    count_busy(n);
    chk_eq("busy_len", n, (glen == 0) ? 1 : glen);
    if (sb.size() == 0) begin
      chk_eq("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      check_result(e);
      tick();
    end
    check_result(e);
    out_ready = 1'b1;
    start = 1'b0;
    tick();
    out_ready = 1'b0;
    chk_eq("valid_after_hs", int'(valid_a), 0);
    chk_eq("busy_after_hs", int'(busy_a), 0);
    tick();
    chk_eq("idle_after_hs", int'(busy_a), 0);
  endtask

  initial begin
    exp_t e;
    int n;
    repeat (2) tick();
    chk_eq("rst_valid", int'(valid_a), 0);
    chk_eq("rst_busy", int'(busy_a), 0);
    chk_eq("rst_out", int'(out_a), 0);
    chk_eq("rst_ovf", int'(ovf_a), 0);
    reset = 1'b0;
    tick();

    // Basic two-channel measurement.
    set_periods(4, 8);
    run_window(16, 4, 2, 0, 0);

    // Saturation in the 4-bit instance, then a clean run with channel 0 static.
    set_periods(4, 4);
    run_window(100, 25, 25, 0, 0);
    set_periods(0, 4);
    run_window(100, 0, 25, 0, 0);

    // Backpressure with start hammered during MEASURE/HOLD.
    set_periods(4, 8);
    run_window(16, 4, 2, 10, 1);

    // Zero-length window acts as one cycle.
    set_periods(0, 0);
    run_window(0, 0, 0, 0, 1);

    // Continuous back-to-back windows.
    set_periods(4, 8);
    gate_len = 10'd8;
    cont = 1'b1;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) sb.push_back('{e0: 2, e1: 1});
    tick();
    for (int w = 0; w < 3; w++) begin
      count_busy(n);
      chk_eq("cont_busy_len", n, 8);
      e = sb.pop_front();
      check_result(e);
      if (w == 2) cont = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    chk_eq("cont_end_idle", int'(busy_a), 0);
    chk_eq("cont_end_valid", int'(valid_a), 0);

    // Reset mid-window discards everything.
    set_periods(4, 4);
    gate_len = 10'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sel_a = 1'b0;
    #1;
    chk_eq("midrst_busy", int'(busy_a), 0);
    chk_eq("midrst_valid", int'(valid_a), 0);
    chk_eq("midrst_out", int'(out_a), 0);
    chk_eq("midrst_ovf", int'(ovf_a), 0);
    repeat (8) tick();
    run_window(20, 5, 5, 0, 0);

    chk_eq("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
